// File: rtl/ps2_keycode_ctrl.sv
// ps2_keycode_ctrl: set-2 scan-code sequencer feeding a first-word-fall-through key event FIFO
module ps2_keycode_ctrl #(
  parameter int DEPTH     = 8,
  parameter int TIMEOUT   = 100000,
  parameter int PAUSE_LEN = 7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CODE_VALID,
  input  logic [7:0] CODE,
  input  logic       CODE_ERR,
  input  logic       RD_EN,
  input  logic       CLR_OVF,
  output logic       EV_VALID,
  output logic [9:0] EV_DATA,
  output logic       OVF,
  output logic [7:0] ERR_CNT,
  output logic       BUSY
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam int PW = $clog2(PAUSE_LEN + 1);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [9:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, busy_q;
  logic [7:0] err_q, err_d;
  logic push, pop, wr, drop, is_e0, is_f0, is_e1, is_pfx;
  logic [9:0] ev;
  always_comb begin
    is_e0 = CODE == 8'hE0;
    is_f0 = CODE == 8'hF0;
    is_e1 = CODE == 8'hE1;
    is_pfx = is_e0 || is_f0;
    state_d = state_q;
    pcnt_d = pcnt_q;
    push = 1'b0;
    ev = '0;
    tmo_d = (CODE_VALID || state_q == IDLE) ? '0 : tmo_q + 1'b1;
    err_d = (CODE_VALID && CODE_ERR && err_q != 8'hFF) ? err_q + 1'b1 : err_q;
    if (CODE_VALID && CODE_ERR) begin
      state_d = IDLE;
      pcnt_d = '0;
    end else if (CODE_VALID) begin
      unique case (state_q)
        IDLE: begin
          state_d = is_e0 ? EXT : is_f0 ? BRK : is_e1 ? PAUSE : IDLE;
          pcnt_d = is_e1 ? PW'(PAUSE_LEN) : pcnt_q;
          push = !(is_pfx || is_e1);
          ev = {2'b00, CODE};
        end
        EXT: begin
          state_d = is_f0 ? EXT_BRK : is_e0 ? EXT : IDLE;
          push = !is_pfx;
          ev = {2'b01, CODE};
        end
        BRK: begin
          state_d = IDLE;
          push = !is_pfx;
          ev = {2'b10, CODE};
        end
        EXT_BRK: begin
          state_d = IDLE;
          push = !is_pfx;
          ev = {2'b11, CODE};
        end
        PAUSE: begin
          pcnt_d = pcnt_q - 1'b1;
          state_d = pcnt_q == PW'(1) ? IDLE : PAUSE;
          push = pcnt_q == PW'(1);
          ev = {2'b01, 8'h77};
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      pcnt_d = '0;
      tmo_d = '0;
    end
    pop = RD_EN && cnt_q != '0;
    wr = push && (cnt_q != (AW+1)'(DEPTH) || pop);
    drop = push && !wr;
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    ovf_d = (ovf_q && !CLR_OVF) || drop;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pcnt_q <= '0;
      tmo_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      err_q <= '0;
      busy_q <= 1'b0;
    end else begin
      if (wr) mem_q[wr_q] <= ev;
      state_q <= state_d;
      pcnt_q <= pcnt_d;
      tmo_q <= tmo_d;
      wr_q <= wr_q + AW'(wr);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      busy_q <= state_d != IDLE;
    end
  end
  assign EV_VALID = cnt_q != '0;
  assign EV_DATA = EV_VALID ? mem_q[rd_q] : '0;
  assign OVF = ovf_q;
  assign ERR_CNT = err_q;
  assign BUSY = busy_q;
endmodule

// File: tb/tb_ps2_keycode_ctrl.sv
// tb_ps2_keycode_ctrl: directed vector table, corner sequences and randomized run against a prefix-flag reference model
module tb_ps2_keycode_ctrl;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 16;
  localparam int PAUSE_LEN = 7;
  logic clk = 1'b0;
  logic rst, code_valid, code_err, rd_en, clr_ovf;
  logic [7:0] code;
  logic ev_valid, ovf, busy;
  logic [9:0] ev_data;
  logic [7:0] err_cnt;
  int checks = 0;
  int failures = 0;
  logic [9:0] q[$];
  bit m_ext, m_brk, m_ovf;
  int m_pause, m_gap, m_err;
  typedef struct {
    bit rs, v;
    logic [7:0] c;
    bit e, r, cl, xv;
    logic [9:0] xd;
    bit xb;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  ps2_keycode_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .PAUSE_LEN(PAUSE_LEN)) dut (
    .CLK(clk), .RST(rst), .CODE_VALID(code_valid), .CODE(code), .CODE_ERR(code_err),
    .RD_EN(rd_en), .CLR_OVF(clr_ovf), .EV_VALID(ev_valid), .EV_DATA(ev_data),
    .OVF(ovf), .ERR_CNT(err_cnt), .BUSY(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  function automatic bit pending();
    return m_ext || m_brk || m_pause > 0;
  endfunction
  task automatic clear_seq();
    m_ext = 0;
    m_brk = 0;
    m_pause = 0;
  endtask
  task automatic model(input bit rs, input bit v, input logic [7:0] c, input bit e, input bit r, input bit cl);
    bit push, pop, drop;
    logic [9:0] ev;
    push = 0;
    ev = '0;
    if (rs) begin
      q.delete();
      clear_seq();
      m_gap = 0;
      m_ovf = 0;
      m_err = 0;
      return;
    end
    if (v && e) begin
      clear_seq();
      m_gap = 0;
      if (m_err < 255) m_err++;
    end else if (v) begin
      m_gap = 0;
      if (m_pause > 0) begin
        m_pause--;
        if (m_pause == 0) begin
          push = 1;
          ev = 10'h177;
        end
      end else if (c == 8'hE1 && !m_ext && !m_brk) m_pause = PAUSE_LEN;
      else if (c == 8'hF0 || c == 8'hE0) begin
        if (m_brk) clear_seq();
        else if (c == 8'hF0) m_brk = 1;
        else m_ext = 1;
      end else begin
        push = 1;
        ev = {m_brk, m_ext, c};
        clear_seq();
      end
    end else if (pending()) begin
      m_gap++;
      if (m_gap == TIMEOUT) clear_seq();
    end
    pop = r && q.size() != 0;
    drop = push && q.size() == DEPTH && !pop;
    if (pop) void'(q.pop_front());
    if (push && !drop) q.push_back(ev);
    m_ovf = (m_ovf && !cl) || drop;
  endtask
  task automatic step(input bit rs, input bit v, input logic [7:0] c, input bit e, input bit r, input bit cl);
    rst = rs;
    code_valid = v;
    code = c;
    code_err = e;
    rd_en = r;
    clr_ovf = cl;
    @(posedge clk);
    model(rs, v, c, e, r, cl);
    #1;
    chk("ev_valid", ev_valid, q.size() != 0);
    chk("ev_data", ev_data, q.size() != 0 ? q[0] : 10'h0);
    chk("ovf", ovf, m_ovf);
    chk("err_cnt", err_cnt, m_err);
    chk("busy", busy, pending());
  endtask
  task automatic byte_in(input logic [7:0] c);
    step(0, 1, c, 0, 0, 0);
  endtask
  task automatic idle(input bit r);
    step(0, 0, 8'h00, 0, r, 0);
  endtask
  task automatic add(input bit rs, input bit v, input logic [7:0] c, input bit e, input bit r,
                     input bit xv, input logic [9:0] xd, input bit xb);
    vec_t t;
    t.rs = rs; t.v = v; t.c = c; t.e = e; t.r = r; t.cl = 0;
    t.xv = xv; t.xd = xd; t.xb = xb;
    tbl.push_back(t);
  endtask
  initial begin
    add(1, 0, 8'h00, 0, 0, 0, 10'h000, 0);
    add(0, 1, 8'h1C, 0, 0, 1, 10'h01C, 0);
    add(0, 1, 8'hF0, 0, 0, 1, 10'h01C, 1);
    add(0, 1, 8'h1C, 0, 0, 1, 10'h01C, 0);
    add(0, 0, 8'h00, 0, 1, 1, 10'h21C, 0);
    add(0, 0, 8'h00, 0, 1, 0, 10'h000, 0);
    add(0, 1, 8'hE0, 0, 0, 0, 10'h000, 1);
    add(0, 1, 8'h75, 0, 0, 1, 10'h175, 0);
    add(0, 1, 8'hE0, 0, 0, 1, 10'h175, 1);
    add(0, 1, 8'hF0, 0, 0, 1, 10'h175, 1);
    add(0, 1, 8'h75, 0, 0, 1, 10'h175, 0);
    add(0, 0, 8'h00, 0, 1, 1, 10'h375, 0);
    add(0, 0, 8'h00, 0, 1, 0, 10'h000, 0);
    add(0, 1, 8'hE1, 0, 0, 0, 10'h000, 1);
    add(0, 1, 8'h14, 0, 0, 0, 10'h000, 1);
    add(0, 1, 8'h77, 0, 0, 0, 10'h000, 1);
    add(0, 1, 8'hE1, 0, 0, 0, 10'h000, 1);
    add(0, 1, 8'hF0, 0, 0, 0, 10'h000, 1);
    add(0, 1, 8'h14, 0, 0, 0, 10'h000, 1);
    add(0, 1, 8'hF0, 0, 0, 0, 10'h000, 1);
    add(0, 1, 8'h77, 0, 0, 1, 10'h177, 0);
    add(0, 0, 8'h00, 0, 1, 0, 10'h000, 0);
    add(0, 1, 8'hE0, 0, 0, 0, 10'h000, 1);
    add(0, 1, 8'h75, 1, 0, 0, 10'h000, 0);
    add(0, 1, 8'h75, 0, 0, 1, 10'h075, 0);
    add(0, 0, 8'h00, 0, 1, 0, 10'h000, 0);
    foreach (tbl[i]) begin
      step(tbl[i].rs, tbl[i].v, tbl[i].c, tbl[i].e, tbl[i].r, tbl[i].cl);
      chk($sformatf("tbl%0d_valid", i), ev_valid, tbl[i].xv);
      chk($sformatf("tbl%0d_data", i), ev_data, tbl[i].xd);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].xb);
    end
    chk("err_after_one", err_cnt, 8'd1);
    byte_in(8'hE0);
    repeat (TIMEOUT - 1) idle(0);
    chk("tmo_not_yet", busy, 1'b1);
    idle(0);
    chk("tmo_expired", busy, 1'b0);
    byte_in(8'h1C);
    chk("tmo_make", ev_data, 10'h01C);
    idle(1);
    for (int i = 0; i <= DEPTH; i++) byte_in(8'h10 + 8'(i));
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_head", ev_data, 10'h010);
    step(0, 1, 8'h20, 0, 1, 0);
    chk("full_push_pop_head", ev_data, 10'h011);
    chk("full_push_pop_ovf", ovf, 1'b1);
    step(0, 0, 8'h00, 0, 0, 1);
    chk("ovf_clr", ovf, 1'b0);
    repeat (DEPTH - 1) idle(1);
    chk("full_push_pop_tail", ev_data, 10'h020);
    idle(1);
    chk("drained", ev_valid, 1'b0);
    repeat (DEPTH) byte_in(8'h31);
    step(0, 1, 8'h32, 0, 0, 1);
    chk("ovf_set_wins", ovf, 1'b1);
    repeat (DEPTH) idle(1);
    step(0, 1, 8'h44, 0, 1, 0);
    chk("empty_push_rd", ev_data, 10'h044);
    repeat (300) step(0, 1, 8'h5A, 1, 0, 0);
    chk("err_saturate", err_cnt, 8'd255);
    byte_in(8'hE0);
    step(1, 0, 8'h00, 0, 0, 0);
    chk("rst_valid", ev_valid, 1'b0);
    chk("rst_err", err_cnt, 8'd0);
    chk("rst_busy", busy, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      bit v, e, r, cl, rs;
      logic [7:0] c;
      int sel;
      v = $urandom_range(0, 99) < (((i / 400) % 2 == 1) ? 3 : 55);
      sel = $urandom_range(0, 9);
      c = sel == 0 ? 8'hE0 : sel == 1 ? 8'hF0 : sel == 2 ? 8'hE1 : 8'($urandom);
      e = $urandom_range(0, 99) < 4;
      r = $urandom_range(0, 99) < (((i / 250) % 2 == 1) ? 8 : 45);
      cl = $urandom_range(0, 99) < 5;
      rs = $urandom_range(0, 999) < 3;
      step(rs, v, c, e, r, cl);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
